// File: rtl/tri_pkg.sv
// Shared types for the triangle rasterizer front end.
// Vertex/triangle layouts match the requester packing {x1,y1,x2,y2,x3,y3}.
package tri_pkg;

  localparam int CW = 3;
  localparam int WAIT_BUSY_MAX = 4;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } vtx_t;

  typedef struct packed {
    vtx_t v1;
    vtx_t v2;
    vtx_t v3;
  } tri_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD1,
    LOAD2,
    LOAD3,
    WAIT_BUSY,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/tri_raster_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i,
// searching upward with wrap.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int k;

  // Walk offsets from far to near so the nearest hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      k = int'(ptr_i) + off;
      if (k >= NREQ) k = k - NREQ;
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = IDW'(k);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tri_raster_arbiter.sv
// Shares one triangle rasterizer between NREQ requesters: grants,
// replays the 3-cycle vertex load, tags the point stream, signals done.
module tri_raster_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 3,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*6*CW-1:0] req_vtx,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rast_nt,
  output logic [CW-1:0]        rast_xi,
  output logic [CW-1:0]        rast_yi,
  input  logic                 rast_busy,
  input  logic                 rast_po,
  input  logic [CW-1:0]        rast_xo,
  input  logic [CW-1:0]        rast_yo,
  output logic                 pt_valid,
  output logic [CW-1:0]        pt_x,
  output logic [CW-1:0]        pt_y,
  output logic [IDW-1:0]       pt_id,
  output logic [NREQ-1:0]      done,
  output logic                 err
);

  import tri_pkg::*;

  localparam int TW = 6 * CW;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  id_q, id_d;
  tri_t            tri_q, tri_d, tri_sel;
  logic [1:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            any;
  logic            fwd;
  logic            ptv_d;
  logic            ptv_q;
  logic [CW-1:0]   ptx_q, pty_q;
  logic [IDW-1:0]  ptid_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (any)
  );

  always_comb begin
    tri_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) tri_sel = req_vtx[i*TW +: TW];
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    tri_d     = tri_q;
    cnt_d     = cnt_q;
    done_d    = '0;
    req_ready = '0;
    rast_nt   = 1'b0;
    rast_xi   = '0;
    rast_yi   = '0;
    err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any && !reset) begin
          req_ready = gnt;
          tri_d     = tri_sel;
          id_d      = gidx;
          rr_d      = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          state_d   = LOAD1;
        end
      end
      LOAD1: begin
        rast_nt = 1'b1;
        rast_xi = tri_q.v1.x;
        rast_yi = tri_q.v1.y;
        state_d = LOAD2;
      end
      LOAD2: begin
        rast_xi = tri_q.v2.x;
        rast_yi = tri_q.v2.y;
        state_d = LOAD3;
      end
      LOAD3: begin
        rast_xi = tri_q.v3.x;
        rast_yi = tri_q.v3.y;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (rast_busy) begin
          state_d = RUN;
        end else if (cnt_q == 2'(WAIT_BUSY_MAX - 1)) begin
          err     = 1'b1;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!rast_busy) state_d = DRAIN;
      end
      DRAIN: begin
        done_d[id_q] = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // DRAIN is included so the point lagging busy still gets forwarded.
  assign fwd   = (state_q == WAIT_BUSY) || (state_q == RUN) ||
                 (state_q == DRAIN);
  assign ptv_d = rast_po & fwd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      tri_q   <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      ptv_q   <= 1'b0;
      ptx_q   <= '0;
      pty_q   <= '0;
      ptid_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      tri_q   <= tri_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ptv_q   <= ptv_d;
      ptx_q   <= ptv_d ? rast_xo : '0;
      pty_q   <= ptv_d ? rast_yo : '0;
      ptid_q  <= ptv_d ? id_q : '0;
    end
  end

  assign pt_valid = ptv_q;
  assign pt_x     = ptx_q;
  assign pt_y     = pty_q;
  assign pt_id    = ptid_q;
  assign done     = done_q;

endmodule
